// File: rtl/video_timing_meas_if.sv
// rtl/video_timing_meas_if.sv - video sync inputs and timing measurement results
//
// Purpose: bundles the pixel-domain sync inputs and the per-frame timing results.
// Ports (signals):
//   vid_vs, vid_hs, vid_de           sync/enable inputs, synchronous to pixel_clk
//   h_total, h_active                clocks per line / de-high clocks per line
//   v_total, v_active                lines per frame / active lines per frame
//   meas_valid                       one-cycle pulse when results update
//   locked                           timing stable
//   sig_lost                         one-cycle pulse on vs timeout
// Modports: master drives the video signals and observes results; slave is the meter.
interface video_timing_meas_if #(
  parameter int CNT_W = 13
);
  logic             vid_vs;
  logic             vid_hs;
  logic             vid_de;
  logic [CNT_W-1:0] h_total;
  logic [CNT_W-1:0] h_active;
  logic [CNT_W-1:0] v_total;
  logic [CNT_W-1:0] v_active;
  logic             meas_valid;
  logic             locked;
  logic             sig_lost;

  modport master (
    output vid_vs, vid_hs, vid_de,
    input  h_total, h_active, v_total, v_active, meas_valid, locked, sig_lost
  );

  modport slave (
    input  vid_vs, vid_hs, vid_de,
    output h_total, h_active, v_total, v_active, meas_valid, locked, sig_lost
  );
endinterface

// File: rtl/video_timing_meas.sv
// rtl/video_timing_meas.sv - per-frame video timing measurement with lock and loss detect
//
// Purpose: measures h total/active and v total/active of the incoming video, commits
// them once per frame on the vs leading edge, asserts locked after STABLE_FRAMES
// identical commits and pulses sig_lost when no vs arrives for TIMEOUT_CLKS clocks.
// Ports:
//   pixel_clk   pixel clock, the only clock
//   sys_rst_n   asynchronous active-low reset
//   bus         video_timing_meas_if.slave: vid_vs/vid_hs/vid_de in, results out
module video_timing_meas #(
  parameter int CNT_W         = 13,
  parameter int STABLE_FRAMES = 3,
  parameter int TIMEOUT_CLKS  = 4000000,
  parameter bit VS_POL        = 1'b1,
  parameter bit HS_POL        = 1'b1
) (
  input logic                pixel_clk,
  input logic                sys_rst_n,
  video_timing_meas_if.slave bus
);

  localparam int               TO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [3:0]       STABLE_N = 4'(STABLE_FRAMES);

  typedef enum logic {S_WAIT_VS, S_MEASURE} state_t;

  // Polarity-normalised syncs: 1 means active.
  logic vs_a, hs_a, de_a;
  assign vs_a = (bus.vid_vs == VS_POL);
  assign hs_a = (bus.vid_hs == HS_POL);
  assign de_a = bus.vid_de;

  logic vs_q, hs_q, de_q;
  logic vs_edge, hs_edge, de_rise, de_fall;
  assign vs_edge = vs_a & ~vs_q;
  assign hs_edge = hs_a & ~hs_q;
  assign de_rise = de_a & ~de_q;
  assign de_fall = ~de_a & de_q;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, h_line_q, h_line_d;
  logic [CNT_W-1:0] de_cnt_q, de_cnt_d, h_act_line_q, h_act_line_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
  logic             sat_q, sat_d, sat_evt;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [CNT_W-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             sig_lost_q, sig_lost_d;
  logic             same_tuple;

  // Line and frame counters. They run in every state; the vs edge restarts the
  // frame counters. sat_evt flags any increment blocked at all-ones, which makes
  // the frame's measurement untrustworthy for lock purposes.
  always_comb begin
    h_cnt_d      = h_cnt_q;
    h_line_d     = h_line_q;
    de_cnt_d     = de_cnt_q;
    h_act_line_d = h_act_line_q;
    v_cnt_d      = v_cnt_q;
    va_cnt_d     = va_cnt_q;
    sat_evt      = 1'b0;

    if (hs_edge) begin
      h_line_d = h_cnt_q;
      h_cnt_d  = CNT_ONE;
    end else if (h_cnt_q == CNT_MAX) begin
      sat_evt = 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + CNT_ONE;
    end

    if (de_fall) begin
      h_act_line_d = de_cnt_q;
      de_cnt_d     = '0;
    end else if (de_a) begin
      if (de_cnt_q == CNT_MAX) sat_evt = 1'b1;
      else                     de_cnt_d = de_cnt_q + CNT_ONE;
    end

    // An hs edge coincident with vs belongs to the new frame.
    if (vs_edge) begin
      v_cnt_d = hs_edge ? CNT_ONE : '0;
    end else if (hs_edge) begin
      if (v_cnt_q == CNT_MAX) sat_evt = 1'b1;
      else                    v_cnt_d = v_cnt_q + CNT_ONE;
    end

    if (vs_edge) begin
      va_cnt_d = '0;
    end else if (de_rise) begin
      if (va_cnt_q == CNT_MAX) sat_evt = 1'b1;
      else                     va_cnt_d = va_cnt_q + CNT_ONE;
    end

    sat_d = vs_edge ? 1'b0 : (sat_q | sat_evt);
  end

  assign same_tuple = (h_line_q == h_total_q) && (h_act_line_q == h_active_q) &&
                      (v_cnt_q == v_total_q) && (va_cnt_q == v_active_q);

  // Control: the first vs edge only arms measurement (that frame was partial);
  // later vs edges commit. A vs edge takes priority over an expiring timeout.
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    match_cnt_d  = match_cnt_q;
    h_total_d    = h_total_q;
    h_active_d   = h_active_q;
    v_total_d    = v_total_q;
    v_active_d   = v_active_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    sig_lost_d   = 1'b0;

    case (state_q)
      S_WAIT_VS: begin
        if (vs_edge) begin
          state_d  = S_MEASURE;
          to_cnt_d = '0;
        end
      end
      S_MEASURE: begin
        if (vs_edge) begin
          to_cnt_d     = '0;
          h_total_d    = h_line_q;
          h_active_d   = h_act_line_q;
          v_total_d    = v_cnt_q;
          v_active_d   = va_cnt_q;
          meas_valid_d = 1'b1;
          if (same_tuple && !sat_q) begin
            match_cnt_d = (match_cnt_q == 4'hf) ? 4'hf : match_cnt_q + 4'd1;
          end else begin
            match_cnt_d = sat_q ? 4'd0 : 4'd1;
          end
          locked_d = (match_cnt_d >= STABLE_N);
        end else if (to_cnt_q == TO_LAST) begin
          to_cnt_d    = '0;
          sig_lost_d  = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = 4'd0;
          state_d     = S_WAIT_VS;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_WAIT_VS;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vs_q         <= 1'b0;
      hs_q         <= 1'b0;
      de_q         <= 1'b0;
      h_cnt_q      <= '0;
      h_line_q     <= '0;
      de_cnt_q     <= '0;
      h_act_line_q <= '0;
      v_cnt_q      <= '0;
      va_cnt_q     <= '0;
      sat_q        <= 1'b0;
      state_q      <= S_WAIT_VS;
      to_cnt_q     <= '0;
      match_cnt_q  <= 4'd0;
      h_total_q    <= '0;
      h_active_q   <= '0;
      v_total_q    <= '0;
      v_active_q   <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sig_lost_q   <= 1'b0;
    end else begin
      vs_q         <= vs_a;
      hs_q         <= hs_a;
      de_q         <= de_a;
      h_cnt_q      <= h_cnt_d;
      h_line_q     <= h_line_d;
      de_cnt_q     <= de_cnt_d;
      h_act_line_q <= h_act_line_d;
      v_cnt_q      <= v_cnt_d;
      va_cnt_q     <= va_cnt_d;
      sat_q        <= sat_d;
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      match_cnt_q  <= match_cnt_d;
      h_total_q    <= h_total_d;
      h_active_q   <= h_active_d;
      v_total_q    <= v_total_d;
      v_active_q   <= v_active_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      sig_lost_q   <= sig_lost_d;
    end
  end

  assign bus.h_total    = h_total_q;
  assign bus.h_active   = h_active_q;
  assign bus.v_total    = v_total_q;
  assign bus.v_active   = v_active_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.sig_lost   = sig_lost_q;

endmodule
